// File: rtl/hpu_intr_arb.sv
// ---------------------------------------------------------------------------
// hpu_intr_arb
//
// Interrupt arbitration stage between the core-local interrupt aggregator and
// the pipeline control / trap logic.
//   * Registers the per-source pending levels (mip layout) and presents the
//     snapshot to the CSR file.
//   * Masks pending bits with mie and mstatus.MIE, picks the single
//     highest-priority source and raises a request to the control unit.
//   * Holds the trap context (busy, cause) until mret retires.
//
// Ports:
//   clk_i                   core clock
//   rst_i                   asynchronous active-low reset
//   clint_ctrl__intr_act_i  per-source pending levels (mip bit positions)
//   csr_intr__mie_i         mie enable mask
//   csr_intr__gie_i         mstatus.MIE
//   csr_intr__dbg_mode_i    debug mode, blocks new requests
//   intr_csr__mip_o         registered pending snapshot for mip reads
//   intr_ctrl__req_o        interrupt request to control
//   intr_ctrl__cause_o      mcause value {1, source index}
//   ctrl_intr__ack_i        control accepted the request (trap taken)
//   ctrl_intr__mret_i       mret retired
//   intr_ctrl__busy_o       high while a request or trap is outstanding
// ---------------------------------------------------------------------------
module hpu_intr_arb #(
    parameter int INTR_WTH  = 32,
    parameter int CAUSE_WTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [INTR_WTH-1:0]  clint_ctrl__intr_act_i,
    input  logic [INTR_WTH-1:0]  csr_intr__mie_i,
    input  logic                 csr_intr__gie_i,
    input  logic                 csr_intr__dbg_mode_i,
    output logic [INTR_WTH-1:0]  intr_csr__mip_o,
    output logic                 intr_ctrl__req_o,
    output logic [CAUSE_WTH-1:0] intr_ctrl__cause_o,
    input  logic                 ctrl_intr__ack_i,
    input  logic                 ctrl_intr__mret_i,
    output logic                 intr_ctrl__busy_o
);

    localparam int IDX_W      = $clog2(INTR_WTH);
    localparam int CAUSE_LO_W = CAUSE_WTH - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_TRAP = 2'b10
    } state_t;

    // Fixed-priority pick: MEI(11) > MSI(3) > MTI(7) > platform sources
    // 16..INTR_WTH-1 (lowest index first). All other bits are reserved and
    // never selected. Returns {valid, index}.
    function automatic logic [IDX_W:0] pick_source(input logic [INTR_WTH-1:0] cand);
        logic [IDX_W:0] res;
        res = {(IDX_W+1){1'b0}};
        if (cand[11]) begin
            res = {1'b1, IDX_W'(32'd11)};
        end else if (cand[3]) begin
            res = {1'b1, IDX_W'(32'd3)};
        end else if (cand[7]) begin
            res = {1'b1, IDX_W'(32'd7)};
        end else begin
            for (int i = 16; i < INTR_WTH; i++) begin
                if (cand[i] && !res[IDX_W]) begin
                    res = {1'b1, IDX_W'(i)};
                end else begin
                    res = res;
                end
            end
        end
        return res;
    endfunction

    state_t                 state_r;
    logic [INTR_WTH-1:0]    mip_r;
    logic [IDX_W-1:0]       sel_idx_r;
    logic                   req_r;
    logic                   busy_r;
    logic [CAUSE_WTH-1:0]   cause_r;

    logic [INTR_WTH-1:0]    cand_s;
    logic [IDX_W:0]         pick_s;
    logic                   sel_valid_s;
    logic [IDX_W-1:0]       sel_s;
    logic                   elig_s;
    logic                   withdraw_s;

    // Pending snapshot: captured every cycle, in every state.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mip_r <= {INTR_WTH{1'b0}};
        end else begin
            mip_r <= clint_ctrl__intr_act_i;
        end
    end

    // Candidate masking, priority selection and withdrawal detection.
    // Eligibility also requires a selectable source, so a candidate vector
    // holding only reserved bits never produces a request with no valid cause.
    always_comb begin
        cand_s      = mip_r & csr_intr__mie_i;
        pick_s      = pick_source(cand_s);
        sel_valid_s = pick_s[IDX_W];
        sel_s       = pick_s[IDX_W-1:0];
        elig_s      = sel_valid_s & csr_intr__gie_i & ~csr_intr__dbg_mode_i;
        withdraw_s  = ~mip_r[sel_idx_r] | ~csr_intr__mie_i[sel_idx_r] | ~csr_intr__gie_i;
    end

    // Request/trap FSM with registered req, busy and cause outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r   <= ST_IDLE;
            sel_idx_r <= {IDX_W{1'b0}};
            req_r     <= 1'b0;
            busy_r    <= 1'b0;
            cause_r   <= {CAUSE_WTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (elig_s) begin
                        state_r   <= ST_REQ;
                        sel_idx_r <= sel_s;
                        cause_r   <= {1'b1, CAUSE_LO_W'(sel_s)};
                        req_r     <= 1'b1;
                        busy_r    <= 1'b1;
                    end else begin
                        req_r  <= 1'b0;
                        busy_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    // Ack has priority over a simultaneous withdrawal; a newly
                    // arrived higher-priority source does not preempt.
                    if (ctrl_intr__ack_i) begin
                        state_r <= ST_TRAP;
                        req_r   <= 1'b0;
                        busy_r  <= 1'b1;
                    end else if (withdraw_s) begin
                        state_r <= ST_IDLE;
                        req_r   <= 1'b0;
                        busy_r  <= 1'b0;
                    end else begin
                        req_r  <= 1'b1;
                        busy_r <= 1'b1;
                    end
                end
                ST_TRAP: begin
                    req_r <= 1'b0;
                    if (ctrl_intr__mret_i) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    req_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign intr_csr__mip_o    = mip_r;
    assign intr_ctrl__req_o   = req_r;
    assign intr_ctrl__busy_o  = busy_r;
    assign intr_ctrl__cause_o = cause_r;

endmodule

// File: tb/tb_hpu_intr_arb.sv
// ---------------------------------------------------------------------------
// tb_hpu_intr_arb
//
// Directed testbench for hpu_intr_arb. Inputs change and outputs are sampled
// on the falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_hpu_intr_arb;

    logic        clk_i;
    logic        rst_i;
    logic [31:0] clint_ctrl__intr_act_i;
    logic [31:0] csr_intr__mie_i;
    logic        csr_intr__gie_i;
    logic        csr_intr__dbg_mode_i;
    logic [31:0] intr_csr__mip_o;
    logic        intr_ctrl__req_o;
    logic [31:0] intr_ctrl__cause_o;
    logic        ctrl_intr__ack_i;
    logic        ctrl_intr__mret_i;
    logic        intr_ctrl__busy_o;

    int n_checks;
    int n_pass;

    hpu_intr_arb #(.INTR_WTH(32), .CAUSE_WTH(32)) dut (
        .clk_i                  (clk_i),
        .rst_i                  (rst_i),
        .clint_ctrl__intr_act_i (clint_ctrl__intr_act_i),
        .csr_intr__mie_i        (csr_intr__mie_i),
        .csr_intr__gie_i        (csr_intr__gie_i),
        .csr_intr__dbg_mode_i   (csr_intr__dbg_mode_i),
        .intr_csr__mip_o        (intr_csr__mip_o),
        .intr_ctrl__req_o       (intr_ctrl__req_o),
        .intr_ctrl__cause_o     (intr_ctrl__cause_o),
        .ctrl_intr__ack_i       (ctrl_intr__ack_i),
        .ctrl_intr__mret_i      (ctrl_intr__mret_i),
        .intr_ctrl__busy_o      (intr_ctrl__busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step(input int n);
        for (int k = 0; k < n; k++) @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        clint_ctrl__intr_act_i = 32'h0; csr_intr__mie_i = 32'h0;
        csr_intr__gie_i = 1'b0; csr_intr__dbg_mode_i = 1'b0;
        ctrl_intr__ack_i = 1'b0; ctrl_intr__mret_i = 1'b0;
        step(3);
        n_checks++; if (intr_ctrl__req_o !== 1'b0) $display("FAIL rst_req got=%0b exp=0", intr_ctrl__req_o); else n_pass++;
        n_checks++; if (intr_ctrl__busy_o !== 1'b0) $display("FAIL rst_busy got=%0b exp=0", intr_ctrl__busy_o); else n_pass++;
        n_checks++; if (intr_ctrl__cause_o !== 32'h0) $display("FAIL rst_cause got=%h exp=00000000", intr_ctrl__cause_o); else n_pass++;
        n_checks++; if (intr_csr__mip_o !== 32'h0) $display("FAIL rst_mip got=%h exp=00000000", intr_csr__mip_o); else n_pass++;
        rst_i = 1'b1;
        step(1);
    endtask

    task automatic test_basic_trap();
        clint_ctrl__intr_act_i = 32'h800; csr_intr__mie_i = 32'h800; csr_intr__gie_i = 1'b1;
        step(1);
        n_checks++; if (intr_csr__mip_o !== 32'h800) $display("FAIL basic_mip got=%h exp=00000800", intr_csr__mip_o); else n_pass++;
        n_checks++; if (intr_ctrl__req_o !== 1'b0) $display("FAIL basic_req_c1 got=%0b exp=0", intr_ctrl__req_o); else n_pass++;
        step(1);
        n_checks++; if (intr_ctrl__req_o !== 1'b1) $display("FAIL basic_req_c2 got=%0b exp=1", intr_ctrl__req_o); else n_pass++;
        n_checks++; if (intr_ctrl__cause_o !== 32'h8000000B) $display("FAIL basic_cause got=%h exp=8000000b", intr_ctrl__cause_o); else n_pass++;
        n_checks++; if (intr_ctrl__busy_o !== 1'b1) $display("FAIL basic_busy_req got=%0b exp=1", intr_ctrl__busy_o); else n_pass++;
        step(1);
        n_checks++; if (intr_ctrl__req_o !== 1'b1) $display("FAIL basic_req_hold got=%0b exp=1", intr_ctrl__req_o); else n_pass++;
        ctrl_intr__ack_i = 1'b1;
        step(1);
        ctrl_intr__ack_i = 1'b0;
        n_checks++; if (intr_ctrl__req_o !== 1'b0) $display("FAIL basic_req_trap got=%0b exp=0", intr_ctrl__req_o); else n_pass++;
        n_checks++; if (intr_ctrl__busy_o !== 1'b1) $display("FAIL basic_busy_trap got=%0b exp=1", intr_ctrl__busy_o); else n_pass++;
        n_checks++; if (intr_ctrl__cause_o !== 32'h8000000B) $display("FAIL basic_cause_trap got=%h exp=8000000b", intr_ctrl__cause_o); else n_pass++;
        // Source still pending: stays in TRAP without mret.
        step(2);
        n_checks++; if (intr_ctrl__busy_o !== 1'b1 || intr_ctrl__req_o !== 1'b0) $display("FAIL basic_trap_hold busy=%0b req=%0b exp busy=1 req=0", intr_ctrl__busy_o, intr_ctrl__req_o); else n_pass++;
        ctrl_intr__mret_i = 1'b1;
        step(1);
        ctrl_intr__mret_i = 1'b0;
        n_checks++; if (intr_ctrl__busy_o !== 1'b0) $display("FAIL basic_busy_mret got=%0b exp=0", intr_ctrl__busy_o); else n_pass++;
        // Level-sensitive re-request two cycles after mret.
        step(1);
        n_checks++; if (intr_ctrl__req_o !== 1'b1) $display("FAIL basic_rereq got=%0b exp=1", intr_ctrl__req_o); else n_pass++;
        clint_ctrl__intr_act_i = 32'h0;
        step(2);
        n_checks++; if (intr_ctrl__req_o !== 1'b0 || intr_ctrl__busy_o !== 1'b0) $display("FAIL basic_withdraw req=%0b busy=%0b exp req=0 busy=0", intr_ctrl__req_o, intr_ctrl__busy_o); else n_pass++;
    endtask

    task automatic run_prio(input logic [31:0] act, input logic [31:0] exp_cause);
        clint_ctrl__intr_act_i = 32'h0;
        step(3);
        clint_ctrl__intr_act_i = act;
        step(2);
        n_checks++; if (intr_ctrl__req_o !== 1'b1 || intr_ctrl__cause_o !== exp_cause) $display("FAIL prio act=%h req=%0b cause=%h exp req=1 cause=%h", act, intr_ctrl__req_o, intr_ctrl__cause_o, exp_cause); else n_pass++;
        clint_ctrl__intr_act_i = 32'h0;
        step(2);
        n_checks++; if (intr_ctrl__req_o !== 1'b0) $display("FAIL prio_drop act=%h req=%0b exp=0", act, intr_ctrl__req_o); else n_pass++;
    endtask

    task automatic test_priority();
        csr_intr__mie_i = 32'hFFFF_FFFF; csr_intr__gie_i = 1'b1;
        run_prio(32'h0000_0888, 32'h8000_000B);
        run_prio(32'h0000_0088, 32'h8000_0003);
        run_prio(32'h0000_0080, 32'h8000_0007);
        run_prio(32'h0003_0000, 32'h8000_0010);
        run_prio(32'h8004_0001, 32'h8000_0012);
    endtask

    task automatic test_no_preempt();
        clint_ctrl__intr_act_i = 32'h80;
        step(2);
        n_checks++; if (intr_ctrl__cause_o !== 32'h8000_0007) $display("FAIL nopre_cause0 got=%h exp=80000007", intr_ctrl__cause_o); else n_pass++;
        clint_ctrl__intr_act_i = 32'h880;
        step(2);
        n_checks++; if (intr_ctrl__req_o !== 1'b1 || intr_ctrl__cause_o !== 32'h8000_0007) $display("FAIL nopre_hold req=%0b cause=%h exp req=1 cause=80000007", intr_ctrl__req_o, intr_ctrl__cause_o); else n_pass++;
        // Withdraw MTI; MEI gets arbitrated after returning to IDLE.
        clint_ctrl__intr_act_i = 32'h800;
        step(2);
        n_checks++; if (intr_ctrl__req_o !== 1'b0) $display("FAIL nopre_idle got=%0b exp=0", intr_ctrl__req_o); else n_pass++;
        step(1);
        n_checks++; if (intr_ctrl__req_o !== 1'b1 || intr_ctrl__cause_o !== 32'h8000_000B) $display("FAIL nopre_mei req=%0b cause=%h exp req=1 cause=8000000b", intr_ctrl__req_o, intr_ctrl__cause_o); else n_pass++;
        clint_ctrl__intr_act_i = 32'h0;
        step(3);
    endtask

    task automatic test_withdraw();
        clint_ctrl__intr_act_i = 32'h80;
        step(2);
        n_checks++; if (intr_ctrl__req_o !== 1'b1) $display("FAIL wd_req got=%0b exp=1", intr_ctrl__req_o); else n_pass++;
        clint_ctrl__intr_act_i = 32'h0;
        step(1);
        n_checks++; if (intr_csr__mip_o !== 32'h0 || intr_ctrl__req_o !== 1'b1) $display("FAIL wd_mip mip=%h req=%0b exp mip=00000000 req=1", intr_csr__mip_o, intr_ctrl__req_o); else n_pass++;
        step(1);
        n_checks++; if (intr_ctrl__req_o !== 1'b0 || intr_ctrl__busy_o !== 1'b0) $display("FAIL wd_fall req=%0b busy=%0b exp req=0 busy=0", intr_ctrl__req_o, intr_ctrl__busy_o); else n_pass++;
        // Ack outside REQ is ignored.
        ctrl_intr__ack_i = 1'b1;
        step(1);
        ctrl_intr__ack_i = 1'b0;
        n_checks++; if (intr_ctrl__busy_o !== 1'b0) $display("FAIL wd_ack_idle got=%0b exp=0", intr_ctrl__busy_o); else n_pass++;
    endtask

    task automatic test_gie();
        csr_intr__gie_i = 1'b0;
        clint_ctrl__intr_act_i = 32'h80;
        step(3);
        n_checks++; if (intr_csr__mip_o !== 32'h80 || intr_ctrl__req_o !== 1'b0) $display("FAIL gie_block mip=%h req=%0b exp mip=00000080 req=0", intr_csr__mip_o, intr_ctrl__req_o); else n_pass++;
        csr_intr__gie_i = 1'b1;
        step(1);
        n_checks++; if (intr_ctrl__req_o !== 1'b1) $display("FAIL gie_enable got=%0b exp=1", intr_ctrl__req_o); else n_pass++;
        csr_intr__gie_i = 1'b0;
        step(1);
        n_checks++; if (intr_ctrl__req_o !== 1'b0 || intr_ctrl__busy_o !== 1'b0) $display("FAIL gie_withdraw req=%0b busy=%0b exp req=0 busy=0", intr_ctrl__req_o, intr_ctrl__busy_o); else n_pass++;
        clint_ctrl__intr_act_i = 32'h0;
        csr_intr__gie_i = 1'b1;
        step(2);
    endtask

    task automatic test_back_to_back();
        clint_ctrl__intr_act_i = 32'h8;
        step(2);
        n_checks++; if (intr_ctrl__cause_o !== 32'h8000_0003) $display("FAIL b2b_cause got=%h exp=80000003", intr_ctrl__cause_o); else n_pass++;
        clint_ctrl__intr_act_i = 32'h0;
        step(1);
        // Withdrawal and ack in the same cycle: ack wins.
        ctrl_intr__ack_i = 1'b1;
        step(1);
        ctrl_intr__ack_i = 1'b0;
        n_checks++; if (intr_ctrl__busy_o !== 1'b1 || intr_ctrl__req_o !== 1'b0) $display("FAIL b2b_trap busy=%0b req=%0b exp busy=1 req=0", intr_ctrl__busy_o, intr_ctrl__req_o); else n_pass++;
        clint_ctrl__intr_act_i = 32'h800;
        step(1);
        n_checks++; if (intr_csr__mip_o !== 32'h800 || intr_ctrl__req_o !== 1'b0 || intr_ctrl__cause_o !== 32'h8000_0003) $display("FAIL b2b_trap_cap mip=%h req=%0b cause=%h exp mip=00000800 req=0 cause=80000003", intr_csr__mip_o, intr_ctrl__req_o, intr_ctrl__cause_o); else n_pass++;
        // Asynchronous reset in the middle of TRAP.
        #2 rst_i = 1'b0;
        #1;
        n_checks++; if (intr_ctrl__req_o !== 1'b0 || intr_ctrl__busy_o !== 1'b0 || intr_ctrl__cause_o !== 32'h0 || intr_csr__mip_o !== 32'h0) $display("FAIL b2b_async_rst req=%0b busy=%0b cause=%h mip=%h exp all 0", intr_ctrl__req_o, intr_ctrl__busy_o, intr_ctrl__cause_o, intr_csr__mip_o); else n_pass++;
        clint_ctrl__intr_act_i = 32'h0;
        step(1);
        rst_i = 1'b1;
        step(1);
        n_checks++; if (intr_ctrl__busy_o !== 1'b0) $display("FAIL b2b_post_rst got=%0b exp=0", intr_ctrl__busy_o); else n_pass++;
        clint_ctrl__intr_act_i = 32'h8;
        step(2);
        n_checks++; if (intr_ctrl__req_o !== 1'b1) $display("FAIL b2b_idle_works got=%0b exp=1", intr_ctrl__req_o); else n_pass++;
        clint_ctrl__intr_act_i = 32'h0;
        step(3);
    endtask

    task automatic test_dbg_mode();
        csr_intr__dbg_mode_i = 1'b1;
        clint_ctrl__intr_act_i = 32'h8; csr_intr__mie_i = 32'h8; csr_intr__gie_i = 1'b1;
        step(3);
        n_checks++; if (intr_ctrl__req_o !== 1'b0 || intr_ctrl__busy_o !== 1'b0) $display("FAIL dbg_block req=%0b busy=%0b exp req=0 busy=0", intr_ctrl__req_o, intr_ctrl__busy_o); else n_pass++;
        csr_intr__dbg_mode_i = 1'b0;
        step(1);
        n_checks++; if (intr_ctrl__req_o !== 1'b1 || intr_ctrl__cause_o !== 32'h8000_0003) $display("FAIL dbg_release req=%0b cause=%h exp req=1 cause=80000003", intr_ctrl__req_o, intr_ctrl__cause_o); else n_pass++;
        // Debug mode does not disturb an outstanding request.
        csr_intr__dbg_mode_i = 1'b1;
        step(2);
        n_checks++; if (intr_ctrl__req_o !== 1'b1) $display("FAIL dbg_req_hold got=%0b exp=1", intr_ctrl__req_o); else n_pass++;
        csr_intr__dbg_mode_i = 1'b0;
        clint_ctrl__intr_act_i = 32'h0;
        step(3);
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_basic_trap();
        test_priority();
        test_no_preempt();
        test_withdraw();
        test_gie();
        test_back_to_back();
        test_dbg_mode();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
